reg_bank_shift: RTL and testbench
=================================

// Module: reg_bank_shift
// PURPOSE
// - Parametrised bank of DEPTH general-purpose registers, each WIDTH bits, feeding the ALU operand path.
// - One write port carries per-cycle mode: hold, load, shift-left or shift-right with serial-in.
// - Two combinational read ports supply ALU operands A and B; optional write-to-read bypass.
// - Successor of the single 8-bit load/clear register; adds depth, shift modes, dual read and sticky shift-out.
// PARAMETERS
// - WIDTH   8  bits per register (>=2)
// - DEPTH   4  number of registers (>=2); AW = $clog2(DEPTH)
// - BYPASS  1  1: a read of the register being written returns its next value; 0: returns its current value
// PORTS
// - clk      in   1      clock, rising edge
// - rst      in   1      asynchronous, active-high reset
// - clr      in   1      synchronous clear of all registers and sout
// - we       in   1      write-port enable
// - waddr    in   AW     register selected for the write-port operation
// - wop      in   2      00 HOLD, 01 LOAD, 10 SHL, 11 SHR
// - wdata    in   WIDTH  load data (LOAD only)
// - sin      in   1      serial bit shifted in (SHL: into bit0; SHR: into bit WIDTH-1)
// - raddr_a  in   AW     read address, port A
// - rdata_a  out  WIDTH  read data, port A (combinational)
// - raddr_b  in   AW     read address, port B
// - rdata_b  out  WIDTH  read data, port B (combinational)
// - sout     out  1      last bit shifted out (registered, sticky)
// BEHAVIOUR
// - Reset: clk and rst are already decided -- rst is asynchronous, active-high; clock is clk. While rst=1, every register and sout = 0 immediately.
// - Priority at each rising edge: rst > clr > we. clr=1 zeroes all registers and sout; any simultaneous write is dropped.
// - we=1, clr=0, waddr<DEPTH, one-cycle latency, so the result is visible after the edge:
//   - HOLD: no change.
//   - LOAD: reg[waddr] <= wdata.
//   - SHL: reg <= {reg[WIDTH-2:0], sin}; sout <= old reg[WIDTH-1].
//   - SHR: reg <= {sin, reg[WIDTH-1:1]}; sout <= old reg[0].
// - sout changes only on SHL/SHR, clr or rst; it holds across HOLD and LOAD.
// - Out-of-range waddr (>=DEPTH, when DEPTH is not a power of 2): the write is ignored; no register and no sout change.
// - Out-of-range raddr_x: rdata_x = 0.
// - Reads are combinational from the current register contents.
// - BYPASS=1: when we=1, clr=0, wop!=HOLD and raddr_x==waddr, rdata_x = the next value of that register.
//   - The bypass path applies to both ports independently.
//   - clr=1 forces both rdata ports to 0 when BYPASS=1.
// - BYPASS=0: no forwarding; the next value appears the cycle after the edge.
// - rst deasserting mid-sequence: the first active edge after release applies normally; there is no warm-up cycle.
// - Only one register changes per cycle; all other registers hold.
// STRUCTURE
// - Shared package reg_bank_pkg holds:
//   - the opcode constants OP_HOLD=2'b00, OP_LOAD=2'b01, OP_SHL=2'b10, OP_SHR=2'b11;
//   - a next_value(cur, op, wdata, sin) function used by both the cell and the bypass path.
// - Sub-module shift_reg_cell: one WIDTH-bit register with rst/clr/en/op/wdata/sin.
//   - Outputs q, the next-value d_next, and shift-out.
//   - Instantiated DEPTH times with en = we & (waddr==i).
// - Top level contains:
//   - the write decoder;
//   - the sout register, whose mux selects the addressed cell's shift-out;
//   - two read muxes plus the bypass compare.
// TESTING (WIDTH=8, DEPTH=4, BYPASS=1 unless noted)
// - Reset: set rst=1 mid-cycle -> all rdata=0 and sout=0 before the next edge. LOAD 8'hA5 to r2 with rst held -> r2 stays 0.
// - Load/read: LOAD r1=8'h3C and r3=8'hC3 -> raddr_a=1 gives 3C, raddr_b=3 gives C3. HOLD to r1 -> r1 stays 3C.
// - Shift: r0=8'h81, then SHL with sin=0 -> r0=8'h02, sout=1. Then SHR with sin=1 -> r0=8'h81, sout=0. Then 7 HOLDs -> sout stays 0.
// - Bypass: r2=8'h10, LOAD r2=8'hFF with raddr_a=raddr_b=2 -> both rdata=FF in the same cycle.
//   - Same case with BYPASS=0 -> both rdata=10 in that cycle, FF in the next.
// - Simultaneous events: all registers nonzero, then clr=1 with we=1 LOAD r1=8'h55 -> all registers 0, sout=0, r1 stays 0.
//   - Same case with DEPTH=3 and waddr=3 -> no register changes.
// - Random cross-check: 500 random cycles of wop/waddr/wdata/sin/raddr with sparse clr and rst.
//   - Compare against a behavioural model every cycle: rdata_a, rdata_b and sout.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the shifting register bank: write opcodes and the
// next-value rule used by both the register cells and the read bypass.
package reg_bank_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_SHR  = 2'b11;

    // Widest register the shared next_value() helper supports; callers
    // zero-extend into this width and truncate the result back.
    localparam int MAX_W = 64;

    // Value a register takes after one write-port operation. cur and wdata
    // are zero-extended to MAX_W, so for SHR the bit at width-1 is empty
    // after the shift and sin can simply be OR-ed in there.
    function automatic logic [MAX_W-1:0] next_value(
        input logic [MAX_W-1:0] cur,
        input logic [1:0]       op,
        input logic [MAX_W-1:0] wdata,
        input logic             sin,
        input int               width
    );
        logic [MAX_W-1:0] nv;
        nv = cur;
        case (op)
            OP_LOAD: nv = wdata;
            OP_SHL:  nv = {cur[MAX_W-2:0], sin};
            OP_SHR:  nv = (cur >> 1) | (MAX_W'(sin) << (width - 1));
            default: nv = cur;
        endcase
        return nv;
    endfunction

endpackage

// File: rtl/shift_reg_cell.sv
// One WIDTH-bit register of the bank. Exposes its next value so the top
// level can forward it to the read ports, and the bit a shift would drop.
module shift_reg_cell
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] wdata,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] d_next,
    output logic             so
);

    // Next value and shift-out bit for the operation currently presented.
    always_comb begin
        d_next = WIDTH'(next_value(MAX_W'(q), op, MAX_W'(wdata), sin, WIDTH));
        so     = (op == OP_SHR) ? q[0] : q[WIDTH-1];
    end

    // Register update: reset, then clear, then the enabled write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d_next;
        end
    end

endmodule

// File: rtl/reg_bank_shift.sv
// Bank of DEPTH shifting registers with one write port, two combinational
// read ports (optionally forwarding the value being written) and a sticky
// shift-out flag holding the last bit dropped by a shift.
module reg_bank_shift
    import reg_bank_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 4,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [1:0]       wop,
    input  logic [WIDTH-1:0] wdata,
    input  logic             sin,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             sout
);

    // One extra bit so addresses can be compared against DEPTH even when
    // DEPTH is a power of two.
    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] q      [DEPTH];
    logic [WIDTH-1:0] d_next [DEPTH];
    logic [DEPTH-1:0] so_vec;
    logic [DEPTH-1:0] en_vec;
    logic             waddr_ok;

    assign waddr_ok = ({1'b0, waddr} < DEPTH_W);

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        assign en_vec[i] = we & (waddr == AW'(i));

        shift_reg_cell #(
            .WIDTH (WIDTH)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .clr    (clr),
            .en     (en_vec[i]),
            .op     (wop),
            .wdata  (wdata),
            .sin    (sin),
            .q      (q[i]),
            .d_next (d_next[i]),
            .so     (so_vec[i])
        );
    end

    // Sticky shift-out: only a shift into an existing register updates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sout <= 1'b0;
        end else if (clr) begin
            sout <= 1'b0;
        end else if (we && waddr_ok && wop[1]) begin
            sout <= so_vec[waddr];
        end
    end

    // Read mux shared by both ports. With forwarding enabled a pending
    // clear or reset reads as zero, since that is the register's next value.
    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] ra);
        logic [WIDTH-1:0] v;
        v = '0;
        if ({1'b0, ra} < DEPTH_W) begin
            v = q[ra];
            if (BYPASS != 0 && we && wop != OP_HOLD && ra == waddr) begin
                v = d_next[ra];
            end
        end
        if (BYPASS != 0 && (rst || clr)) begin
            v = '0;
        end
        return v;
    endfunction

    // Two independent combinational read ports.
    always_comb begin
        rdata_a = read_port(raddr_a);
        rdata_b = read_port(raddr_b);
    end

endmodule

// File: tb/tb_reg_bank_shift.sv
// Bench for reg_bank_shift: three instances (default, no forwarding,
// DEPTH=3) share one stimulus stream and are each checked against an
// arithmetic model of the register bank on every cycle.
module tb_reg_bank_shift;

    logic       clk = 1'b0;
    logic       rst, clr, we, sin;
    logic [1:0] waddr, wop, raddr_a, raddr_b;
    logic [7:0] wdata;

    logic [7:0] ra0, rb0, ra1, rb1, ra2, rb2;
    logic       so0, so1, so2;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per configuration: 0 = DEPTH 4 bypass, 1 = DEPTH 4 no
    // bypass, 2 = DEPTH 3 bypass.
    int unsigned mreg  [3][4];
    bit          msout [3];
    int          dep   [3] = '{4, 4, 3};
    bit          byp   [3] = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    reg_bank_shift #(.WIDTH(8), .DEPTH(4), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wop(wop),
        .wdata(wdata), .sin(sin), .raddr_a(raddr_a), .rdata_a(ra0),
        .raddr_b(raddr_b), .rdata_b(rb0), .sout(so0)
    );

    reg_bank_shift #(.WIDTH(8), .DEPTH(4), .BYPASS(0)) u_dut_nobyp (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wop(wop),
        .wdata(wdata), .sin(sin), .raddr_a(raddr_a), .rdata_a(ra1),
        .raddr_b(raddr_b), .rdata_b(rb1), .sout(so1)
    );

    reg_bank_shift #(.WIDTH(8), .DEPTH(3), .BYPASS(1)) u_dut_d3 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wop(wop),
        .wdata(wdata), .sin(sin), .raddr_a(raddr_a), .rdata_a(ra2),
        .raddr_b(raddr_b), .rdata_b(rb2), .sout(so2)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned next_of(input int unsigned cur);
        case (wop)
            2'd1:    return int'(wdata);
            2'd2:    return (cur * 2 + int'(sin)) % 256;
            2'd3:    return cur / 2 + int'(sin) * 128;
            default: return cur;
        endcase
    endfunction

    function automatic logic [7:0] exp_rd(input int c, input int ra);
        if (ra >= dep[c]) return 8'h00;
        if (byp[c] && (rst || clr)) return 8'h00;
        if (byp[c] && we && wop != 2'd0 && ra == int'(waddr)) return 8'(next_of(mreg[c][ra]));
        return 8'(mreg[c][ra]);
    endfunction

    task automatic model_zero();
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 4; r++) mreg[c][r] = 0;
            msout[c] = 1'b0;
        end
    endtask

    task automatic model_edge();
        int w;
        w = int'(waddr);
        if (rst || clr) begin
            model_zero();
        end else if (we) begin
            for (int c = 0; c < 3; c++) begin
                if (w < dep[c]) begin
                    if (wop == 2'd2) msout[c] = ((mreg[c][w] / 128) % 2) == 1;
                    if (wop == 2'd3) msout[c] = (mreg[c][w] % 2) == 1;
                    mreg[c][w] = next_of(mreg[c][w]);
                end
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [7:0] oa [3];
        logic [7:0] ob [3];
        logic       os [3];
        oa = '{ra0, ra1, ra2};
        ob = '{rb0, rb1, rb2};
        os = '{so0, so1, so2};
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("%s/cfg%0d/rdata_a", tag, c), oa[c], exp_rd(c, int'(raddr_a)));
            chk($sformatf("%s/cfg%0d/rdata_b", tag, c), ob[c], exp_rd(c, int'(raddr_b)));
            chk($sformatf("%s/cfg%0d/sout", tag, c), {7'd0, os[c]}, {7'd0, msout[c]});
        end
    endtask

    // Apply inputs (called just after a falling edge) and let them settle.
    task automatic drive(input logic r, input logic c, input logic w, input logic [1:0] a,
                         input logic [1:0] op, input logic [7:0] d, input logic s,
                         input logic [1:0] xa, input logic [1:0] xb);
        rst = r; clr = c; we = w; waddr = a; wop = op; wdata = d; sin = s;
        raddr_a = xa; raddr_b = xb;
        #1;
        if (rst) model_zero();
    endtask

    // Check all outputs against the model, then take one clock edge.
    task automatic step(input string tag);
        compare_all(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        model_zero();
        rst = 1'b1; clr = 1'b0; we = 1'b0; waddr = '0; wop = '0; wdata = '0; sin = 1'b0;
        raddr_a = '0; raddr_b = '0;
        @(negedge clk);

        // Reset behaviour
        drive(1, 0, 0, 0, 2'd0, 8'h00, 0, 0, 2);
        step("reset");
        drive(0, 0, 1, 2, 2'd1, 8'h11, 0, 2, 2);
        step("load_r2");
        drive(0, 0, 0, 0, 2'd0, 8'h00, 0, 2, 2);
        chk("r2_loaded", ra0, 8'h11);
        step("pre_rst");
        @(posedge clk); #2;
        rst = 1'b1; #1; model_zero();
        chk("rst_async_rdata", ra0, 8'h00);
        chk("rst_async_rdata_nobyp", ra1, 8'h00);
        @(negedge clk);
        drive(1, 0, 1, 2, 2'd1, 8'hA5, 0, 2, 2);
        step("load_in_rst");
        drive(0, 0, 0, 0, 2'd0, 8'h00, 0, 2, 2);
        chk("r2_after_rst", ra0, 8'h00);
        step("post_rst");

        // Load and read
        drive(0, 0, 1, 1, 2'd1, 8'h3C, 0, 0, 0);
        step("load_r1");
        drive(0, 0, 1, 3, 2'd1, 8'hC3, 0, 0, 0);
        step("load_r3");
        drive(0, 0, 1, 1, 2'd0, 8'hFF, 1, 1, 3);
        chk("read_a_r1", ra0, 8'h3C);
        chk("read_b_r3", rb0, 8'hC3);
        step("hold_r1");
        drive(0, 0, 0, 0, 2'd0, 8'h00, 0, 1, 3);
        chk("r1_after_hold", ra0, 8'h3C);
        step("read_after_hold");

        // Shifts and sticky sout
        drive(0, 0, 1, 0, 2'd1, 8'h81, 0, 0, 0);
        step("load_r0");
        drive(0, 0, 1, 0, 2'd2, 8'h00, 0, 1, 1);
        step("shl_r0");
        drive(0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 0);
        chk("shl_value", ra0, 8'h02);
        chk("shl_sout", {7'd0, so0}, 8'h01);
        step("after_shl");
        drive(0, 0, 1, 0, 2'd3, 8'h00, 1, 1, 1);
        step("shr_r0");
        drive(0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 0);
        chk("shr_value", ra0, 8'h81);
        chk("shr_sout", {7'd0, so0}, 8'h00);
        step("after_shr");
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 1, 0, 2'd0, 8'hFF, 1, 0, 0);
            step("hold_seq");
        end
        chk("sout_held", {7'd0, so0}, 8'h00);

        // Write-to-read forwarding
        drive(0, 0, 1, 2, 2'd1, 8'h10, 0, 0, 0);
        step("load_r2_10");
        drive(0, 0, 1, 2, 2'd1, 8'hFF, 0, 2, 2);
        chk("bypass_a", ra0, 8'hFF);
        chk("bypass_b", rb0, 8'hFF);
        chk("nobypass_a", ra1, 8'h10);
        chk("nobypass_b", rb1, 8'h10);
        step("load_r2_ff");
        drive(0, 0, 0, 0, 2'd0, 8'h00, 0, 2, 2);
        chk("nobypass_next_a", ra1, 8'hFF);
        chk("nobypass_next_b", rb1, 8'hFF);
        step("after_ff");

        // Clear racing a write, with sout set beforehand
        drive(0, 0, 1, 3, 2'd2, 8'h00, 0, 3, 3);
        step("shl_r3");
        drive(0, 0, 1, 1, 2'd1, 8'h55, 0, 1, 1);
        clr = 1'b1; #1;
        chk("clr_bypass_zero", ra0, 8'h00);
        step("clr_with_load");
        for (int r = 0; r < 4; r++) begin
            drive(0, 0, 0, 0, 2'd0, 8'h00, 0, 2'(r), 1);
            chk("clr_reg_zero", ra0, 8'h00);
            chk("clr_r1_zero", rb0, 8'h00);
            step("after_clr");
        end
        chk("clr_sout", {7'd0, so0}, 8'h00);

        // Out-of-range write on the DEPTH=3 instance
        drive(0, 0, 1, 0, 2'd1, 8'h77, 0, 0, 0);
        step("load_r0_77");
        drive(0, 0, 1, 2, 2'd1, 8'h80, 0, 0, 0);
        step("load_r2_80");
        drive(0, 0, 1, 2, 2'd2, 8'h00, 0, 0, 0);
        step("shl_r2_sout1");
        drive(0, 0, 1, 3, 2'd1, 8'hEE, 0, 0, 3);
        step("oob_load");
        drive(0, 0, 1, 3, 2'd3, 8'h00, 1, 0, 2);
        step("oob_shr");
        drive(0, 0, 0, 0, 2'd0, 8'h00, 0, 0, 2);
        chk("d3_r0_kept", ra2, 8'h77);
        chk("d3_r2_kept", rb2, 8'h00);
        chk("d3_sout_kept", {7'd0, so2}, 8'h01);
        step("after_oob");
        drive(0, 1, 1, 3, 2'd1, 8'h55, 0, 0, 1);
        step("d3_clr_oob");

        // Randomized cross-check
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom),
                  8'($urandom), 1'($urandom), 2'($urandom), 2'($urandom));
            step("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
